// File: rtl/imuldiv_div_arbiter_if.sv
//----------------------------------------------------------------------------
// imuldiv_div_arbiter_if
//
// Purpose:
//   Bundles every handshake and payload signal around the divide arbiter:
//   the two requester ports (request and response), the request and
//   response channels to the shared iterative divider, and the busy flag.
//
// Modports:
//   slave  - the arbiter's view. It takes requests and divider responses,
//            and drives ready/valid back together with the registered
//            payloads.
//   master - the surrounding environment's view (requesters plus the
//            divider). This is the exact mirror of slave.
//
// Signal summary:
//   reqN_val/reqN_rdy, reqN_msg_fn/a/b   requester N divide request
//   respN_val/respN_rdy                  requester N response handshake
//   resp_msg_result                      shared {remainder, quotient}
//   divreq_val/rdy, divreq_msg_fn/a/b    request to the divider
//   divresp_val/rdy, divresp_msg_result  response from the divider
//   busy                                 an operation is in progress
//----------------------------------------------------------------------------
interface imuldiv_div_arbiter_if;

   logic        req0_val;
   logic        req0_rdy;
   logic        req0_msg_fn;
   logic [31:0] req0_msg_a;
   logic [31:0] req0_msg_b;

   logic        req1_val;
   logic        req1_rdy;
   logic        req1_msg_fn;
   logic [31:0] req1_msg_a;
   logic [31:0] req1_msg_b;

   logic        resp0_val;
   logic        resp0_rdy;
   logic        resp1_val;
   logic        resp1_rdy;
   logic [63:0] resp_msg_result;

   logic        divreq_val;
   logic        divreq_rdy;
   logic        divreq_msg_fn;
   logic [31:0] divreq_msg_a;
   logic [31:0] divreq_msg_b;

   logic        divresp_val;
   logic        divresp_rdy;
   logic [63:0] divresp_msg_result;

   logic        busy;

   // The arbiter's side of the bundle
   modport slave (
      input  req0_val, req0_msg_fn, req0_msg_a, req0_msg_b,
      input  req1_val, req1_msg_fn, req1_msg_a, req1_msg_b,
      output req0_rdy, req1_rdy,
      output resp0_val, resp1_val, resp_msg_result,
      input  resp0_rdy, resp1_rdy,
      output divreq_val, divreq_msg_fn, divreq_msg_a, divreq_msg_b,
      input  divreq_rdy,
      input  divresp_val, divresp_msg_result,
      output divresp_rdy,
      output busy
   );

   // The environment's side of the bundle (requesters and divider)
   modport master (
      output req0_val, req0_msg_fn, req0_msg_a, req0_msg_b,
      output req1_val, req1_msg_fn, req1_msg_a, req1_msg_b,
      input  req0_rdy, req1_rdy,
      input  resp0_val, resp1_val, resp_msg_result,
      output resp0_rdy, resp1_rdy,
      input  divreq_val, divreq_msg_fn, divreq_msg_a, divreq_msg_b,
      output divreq_rdy,
      output divresp_val, divresp_msg_result,
      input  divresp_rdy,
      input  busy
   );

endinterface

// File: rtl/imuldiv_div_arbiter.sv
//----------------------------------------------------------------------------
// imuldiv_div_arbiter
//
// Purpose:
//   Shares one iterative divider between two requesters. Requests are
//   arbitrated round-robin. The winner's operands are registered and sent
//   to the divider, and the divider's result is registered and returned to
//   the winner. Only one operation is in flight at any time, and no new
//   request is taken until the previous response has been delivered.
//
// Parameters:
//   PRIO_INIT  requester index (0 or 1) that holds priority after reset.
//
// Ports:
//   clk        rising-edge clock for all state.
//   reset      synchronous, active-low reset.
//   div_reset  active-high reset for the divider (inverted reset), so the
//              divider drops any in-flight work in the same cycle.
//   bus        imuldiv_div_arbiter_if.slave with all requester and
//              divider handshakes.
//----------------------------------------------------------------------------
module imuldiv_div_arbiter #(
   parameter int unsigned PRIO_INIT = 0
) (
   input  logic clk,
   input  logic reset,
   output logic div_reset,
   imuldiv_div_arbiter_if.slave bus
);

   // One operation walks IDLE -> ISSUE -> WAIT -> RESP -> IDLE
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam logic PRIO_RESET = PRIO_INIT[0];

   state_t      state_q;
   state_t      state_d;

   logic        prio_q;
   logic        owner_q;
   logic        fn_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [63:0] result_q;

   logic        grant0;
   logic        grant1;
   logic        owner_resp_rdy;

   // The owner's response-ready, selected so that RESP can wait on the
   // single requester that is being served.
   assign owner_resp_rdy = owner_q ? bus.resp1_rdy : bus.resp0_rdy;

   // Next-state and grant logic. Grants exist only in IDLE. A lone valid
   // requester wins outright. When both are valid the priority holder
   // wins. A requester that drops valid before it is granted leaves no
   // trace, because nothing is latched until a grant occurs.
   always_comb begin
      state_d = state_q;
      grant0  = 1'b0;
      grant1  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            grant0 = bus.req0_val && (!bus.req1_val || !prio_q);
            grant1 = bus.req1_val && (!bus.req0_val ||  prio_q);
            if (grant0 || grant1) begin
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (bus.divreq_rdy) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.divresp_val) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (owner_resp_rdy) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register. A reset in any state, including mid-WAIT, abandons
   // the current operation and returns to IDLE without a response.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers. On a grant, the winner's payload and id are
   // captured and priority passes to the other requester. Priority moves
   // only here, so a requester that loses or withdraws keeps its claim.
   // The divider result is captured on the WAIT handshake and is then held
   // for as long as the owner keeps its response stalled.
   always_ff @(posedge clk) begin
      if (!reset) begin
         prio_q   <= PRIO_RESET;
         owner_q  <= 1'b0;
         fn_q     <= 1'b0;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         result_q <= 64'd0;
      end else begin
         if (grant0 || grant1) begin
            owner_q <= grant1;
            prio_q  <= grant0;
            fn_q    <= grant1 ? bus.req1_msg_fn : bus.req0_msg_fn;
            a_q     <= grant1 ? bus.req1_msg_a  : bus.req0_msg_a;
            b_q     <= grant1 ? bus.req1_msg_b  : bus.req0_msg_b;
         end
         if (state_q == ST_WAIT && bus.divresp_val) begin
            result_q <= bus.divresp_msg_result;
         end
      end
   end

   // Requester-ready is the only output that depends on inputs. Everything
   // else comes from state and registers, so downstream timing stays clean.
   assign bus.req0_rdy = grant0;
   assign bus.req1_rdy = grant1;

   assign bus.divreq_val    = (state_q == ST_ISSUE);
   assign bus.divreq_msg_fn = fn_q;
   assign bus.divreq_msg_a  = a_q;
   assign bus.divreq_msg_b  = b_q;

   assign bus.divresp_rdy = (state_q == ST_WAIT);

   assign bus.resp0_val       = (state_q == ST_RESP) && !owner_q;
   assign bus.resp1_val       = (state_q == ST_RESP) &&  owner_q;
   assign bus.resp_msg_result = result_q;

   assign bus.busy  = (state_q != ST_IDLE);
   assign div_reset = ~reset;

endmodule

// File: tb/tb_imuldiv_div_arbiter.sv
//----------------------------------------------------------------------------
// tb_imuldiv_div_arbiter
//
// Purpose:
//   Drives two requesters and a model of the shared divider around the
//   arbiter. It checks every output on every cycle against a
//   transaction-level model of the arbitration and handshake rules, and it
//   pins the model with hand-computed results for directed scenarios.
//----------------------------------------------------------------------------
module tb_imuldiv_div_arbiter;

   localparam int P_IDLE  = 0;
   localparam int P_ISSUE = 1;
   localparam int P_WAIT  = 2;
   localparam int P_RESP  = 3;

   typedef struct {
      logic        fn;
      logic [31:0] a;
      logic [31:0] b;
   } req_t;

   typedef struct {
      int          owner;
      logic [63:0] dut_res;
      logic [63:0] mdl_res;
   } done_t;

   logic clk = 1'b0;
   logic reset_n;
   logic div_reset;

   imuldiv_div_arbiter_if bus();

   imuldiv_div_arbiter #(.PRIO_INIT(0)) dut (
      .clk       (clk),
      .reset     (reset_n),
      .div_reset (div_reset),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   req_t  pend0[$];
   req_t  pend1[$];
   done_t done_q[$];
   int    grant_log[$];
   bit    resp1_seen;

   // Reference model: the operation in progress and the round-robin priority
   int          m_phase;
   int          m_owner;
   int          m_prio;
   req_t        m_op;
   logic [63:0] m_result;
   bit          model_valid = 1'b0;

   // Environment knobs
   bit          auto_push;
   int          resp_force0;
   int          resp_force1;
   int          lat_min;
   int          lat_max;
   int          divreq_rdy_pct;
   bit          div_pend;
   int          div_cnt;
   logic [63:0] div_res;

   // Compare one value against its expected value and log any failure
   task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Divider behaviour: {remainder, quotient} with signed or unsigned rules
   function automatic logic [63:0] div_model(logic fn, logic [31:0] a, logic [31:0] b);
      logic [31:0] q;
      logic [31:0] r;
      if (fn) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         r = a % b;
      end
      return {r, q};
   endfunction

   // Random request. The divisor is never 0 and never -1.
   function automatic req_t rand_req();
      req_t r;
      r.fn = 1'($urandom_range(0, 1));
      r.a  = $urandom;
      r.b  = 32'($urandom_range(2, 5000));
      if (r.fn && $urandom_range(0, 1) == 1) r.b = -r.b;
      return r;
   endfunction

   // Grant rule: a lone valid requester wins, otherwise the priority holder
   function automatic int m_grant();
      if (bus.req0_val && bus.req1_val) return m_prio;
      if (bus.req0_val) return 0;
      if (bus.req1_val) return 1;
      return -1;
   endfunction

   // One clock cycle. At the rising edge this task samples the handshakes
   // and advances the model. One unit later it drives the next inputs from
   // the requester queues and the divider model.
   task automatic applyStimulus();
      bit          acc0;
      bit          acc1;
      bit          dreq;
      bit          dresp;
      int          g;
      logic        dfn;
      logic [31:0] da;
      logic [31:0] db;
      @(posedge clk);
      acc0  = reset_n && bus.req0_val && bus.req0_rdy;
      acc1  = reset_n && bus.req1_val && bus.req1_rdy;
      dreq  = reset_n && bus.divreq_val && bus.divreq_rdy;
      dresp = reset_n && bus.divresp_val && bus.divresp_rdy;
      dfn   = bus.divreq_msg_fn;
      da    = bus.divreq_msg_a;
      db    = bus.divreq_msg_b;
      if (acc0) grant_log.push_back(0);
      if (acc1) grant_log.push_back(1);
      if (bus.resp1_val) resp1_seen = 1'b1;

      if (!reset_n) begin
         m_phase  = P_IDLE;
         m_prio   = 0;
         m_owner  = 0;
         m_op     = '{fn: 1'b0, a: 32'd0, b: 32'd0};
         m_result = 64'd0;
      end else begin
         case (m_phase)
            P_IDLE: begin
               g = m_grant();
               if (g >= 0) begin
                  m_owner = g;
                  if (g == 0) m_op = '{fn: bus.req0_msg_fn, a: bus.req0_msg_a, b: bus.req0_msg_b};
                  else        m_op = '{fn: bus.req1_msg_fn, a: bus.req1_msg_a, b: bus.req1_msg_b};
                  m_prio  = 1 - g;
                  m_phase = P_ISSUE;
               end
            end
            P_ISSUE: if (bus.divreq_rdy) m_phase = P_WAIT;
            P_WAIT: begin
               if (bus.divresp_val) begin
                  m_result = bus.divresp_msg_result;
                  m_phase  = P_RESP;
               end
            end
            default: begin
               if ((m_owner == 0) ? bus.resp0_rdy : bus.resp1_rdy) begin
                  done_q.push_back('{owner: m_owner, dut_res: bus.resp_msg_result, mdl_res: m_result});
                  m_phase = P_IDLE;
               end
            end
         endcase
      end
      model_valid = 1'b1;

      #1;
      if (acc0) void'(pend0.pop_front());
      if (acc1) void'(pend1.pop_front());
      if (auto_push) begin
         if (!acc0 && pend0.size() > 0 && $urandom_range(0, 19) == 0) void'(pend0.pop_front());
         if (!acc1 && pend1.size() > 0 && $urandom_range(0, 19) == 0) void'(pend1.pop_front());
         if (pend0.size() == 0 && $urandom_range(0, 99) < 30) pend0.push_back(rand_req());
         if (pend1.size() == 0 && $urandom_range(0, 99) < 30) pend1.push_back(rand_req());
      end
      bus.req0_val    = (pend0.size() > 0);
      bus.req0_msg_fn = (pend0.size() > 0) ? pend0[0].fn : 1'($urandom_range(0, 1));
      bus.req0_msg_a  = (pend0.size() > 0) ? pend0[0].a  : $urandom;
      bus.req0_msg_b  = (pend0.size() > 0) ? pend0[0].b  : $urandom;
      bus.req1_val    = (pend1.size() > 0);
      bus.req1_msg_fn = (pend1.size() > 0) ? pend1[0].fn : 1'($urandom_range(0, 1));
      bus.req1_msg_a  = (pend1.size() > 0) ? pend1[0].a  : $urandom;
      bus.req1_msg_b  = (pend1.size() > 0) ? pend1[0].b  : $urandom;
      bus.resp0_rdy   = (resp_force0 < 0) ? 1'($urandom_range(0, 1)) : (resp_force0 != 0);
      bus.resp1_rdy   = (resp_force1 < 0) ? 1'($urandom_range(0, 1)) : (resp_force1 != 0);
      bus.divreq_rdy  = ($urandom_range(0, 99) < divreq_rdy_pct);

      if (!reset_n) begin
         div_pend        = 1'b0;
         bus.divresp_val = 1'b0;
      end else begin
         if (dresp) div_pend = 1'b0;
         if (dreq) begin
            div_pend = 1'b1;
            div_cnt  = $urandom_range(lat_min, lat_max);
            div_res  = div_model(dfn, da, db);
         end
         bus.divresp_val = 1'b0;
         if (div_pend) begin
            if (div_cnt > 0) div_cnt--;
            else bus.divresp_val = 1'b1;
         end
      end
      bus.divresp_msg_result = div_pend ? div_res : {$urandom, $urandom};
   endtask

   // Run until n responses have been delivered, within a cycle budget
   task automatic wait_done(string name, int n, int budget);
      while (done_q.size() < n && budget > 0) begin
         applyStimulus();
         budget--;
      end
      checkOutput(name, 64'(done_q.size()), 64'(n));
   endtask

   // Cycle-by-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (model_valid) begin
         checkOutput("req0_rdy", 64'(bus.req0_rdy), 64'(m_phase == P_IDLE && m_grant() == 0));
         checkOutput("req1_rdy", 64'(bus.req1_rdy), 64'(m_phase == P_IDLE && m_grant() == 1));
         checkOutput("busy", 64'(bus.busy), 64'(m_phase != P_IDLE));
         checkOutput("divreq_val", 64'(bus.divreq_val), 64'(m_phase == P_ISSUE));
         checkOutput("divresp_rdy", 64'(bus.divresp_rdy), 64'(m_phase == P_WAIT));
         checkOutput("resp0_val", 64'(bus.resp0_val), 64'(m_phase == P_RESP && m_owner == 0));
         checkOutput("resp1_val", 64'(bus.resp1_val), 64'(m_phase == P_RESP && m_owner == 1));
         if (m_phase == P_ISSUE) begin
            checkOutput("divreq_msg", {31'd0, bus.divreq_msg_fn, bus.divreq_msg_a},
                        {31'd0, m_op.fn, m_op.a});
            checkOutput("divreq_msg_b", 64'(bus.divreq_msg_b), 64'(m_op.b));
         end
         if (m_phase == P_RESP) checkOutput("resp_msg_result", bus.resp_msg_result, m_result);
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset_n        = 1'b0;
      auto_push      = 1'b0;
      resp_force0    = 1;
      resp_force1    = 1;
      lat_min        = 0;
      lat_max        = 4;
      divreq_rdy_pct = 60;
      div_pend       = 1'b0;
      div_cnt        = 0;
      div_res        = 64'd0;
      resp1_seen     = 1'b0;
      m_phase        = P_IDLE;
      m_owner        = 0;
      m_prio         = 0;
      m_result       = 64'd0;
      m_op           = '{fn: 1'b0, a: 32'd0, b: 32'd0};
      bus.req0_val = 1'b0; bus.req0_msg_fn = 1'b0; bus.req0_msg_a = 32'd0; bus.req0_msg_b = 32'd0;
      bus.req1_val = 1'b0; bus.req1_msg_fn = 1'b0; bus.req1_msg_a = 32'd0; bus.req1_msg_b = 32'd0;
      bus.resp0_rdy = 1'b0; bus.resp1_rdy = 1'b0;
      bus.divreq_rdy = 1'b0; bus.divresp_val = 1'b0; bus.divresp_msg_result = 64'd0;

      // Reset state
      repeat (3) applyStimulus();
      checkOutput("rst_busy", 64'(bus.busy), 64'd0);
      checkOutput("rst_resp0_val", 64'(bus.resp0_val), 64'd0);
      checkOutput("rst_resp1_val", 64'(bus.resp1_val), 64'd0);
      checkOutput("rst_divreq_val", 64'(bus.divreq_val), 64'd0);
      checkOutput("rst_divresp_rdy", 64'(bus.divresp_rdy), 64'd0);
      checkOutput("rst_result", bus.resp_msg_result, 64'd0);
      checkOutput("rst_div_reset", 64'(div_reset), 64'd1);
      checkOutput("pin_div_unsigned", div_model(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
      checkOutput("pin_div_signed", div_model(1'b1, -32'sd7, 32'd2), 64'hFFFFFFFF_FFFFFFFD);

      // Both requesters valid in the first cycle after reset
      grant_log.delete(); done_q.delete();
      pend0.push_back('{fn: 1'b0, a: 32'd20, b: 32'd3});
      pend1.push_back('{fn: 1'b0, a: 32'd9,  b: 32'd4});
      applyStimulus();
      reset_n = 1'b1;
      wait_done("both_done", 2, 200);
      if (done_q.size() == 2) begin
         checkOutput("both_first_owner", 64'(done_q[0].owner), 64'd0);
         checkOutput("both_first_result", done_q[0].dut_res, 64'h00000002_00000006);
         checkOutput("both_second_owner", 64'(done_q[1].owner), 64'd1);
         checkOutput("both_second_result", done_q[1].dut_res, 64'h00000001_00000002);
      end

      // Single unsigned request on port 0
      done_q.delete(); resp1_seen = 1'b0;
      pend0.push_back('{fn: 1'b0, a: 32'd100, b: 32'd7});
      wait_done("single_done", 1, 200);
      if (done_q.size() == 1) begin
         checkOutput("single_owner", 64'(done_q[0].owner), 64'd0);
         checkOutput("single_result", done_q[0].dut_res, 64'h00000002_0000000E);
      end
      checkOutput("single_no_resp1", 64'(resp1_seen), 64'd0);

      // Continuous contention alternates grants
      reset_n = 1'b0;
      grant_log.delete(); done_q.delete();
      for (int i = 0; i < 2; i++) begin
         pend0.push_back(rand_req());
         pend1.push_back(rand_req());
      end
      repeat (2) applyStimulus();
      reset_n = 1'b1;
      wait_done("rr_done", 4, 400);
      if (grant_log.size() == 4) begin
         checkOutput("rr_grant0", 64'(grant_log[0]), 64'd0);
         checkOutput("rr_grant1", 64'(grant_log[1]), 64'd1);
         checkOutput("rr_grant2", 64'(grant_log[2]), 64'd0);
         checkOutput("rr_grant3", 64'(grant_log[3]), 64'd1);
      end else begin
         checkOutput("rr_grant_count", 64'(grant_log.size()), 64'd4);
      end

      // Signed request on port 1
      done_q.delete();
      pend1.push_back('{fn: 1'b1, a: -32'sd7, b: 32'd2});
      wait_done("signed_done", 1, 200);
      if (done_q.size() == 1) begin
         checkOutput("signed_owner", 64'(done_q[0].owner), 64'd1);
         checkOutput("signed_result", done_q[0].dut_res, 64'hFFFFFFFF_FFFFFFFD);
      end

      // Response stalled for 10 cycles, then delivered on the first ready
      begin
         int budget;
         done_q.delete();
         resp_force0 = 0;
         pend0.push_back('{fn: 1'b0, a: 32'd50, b: 32'd8});
         budget = 100;
         while (!bus.resp0_val && budget > 0) begin
            applyStimulus();
            budget--;
         end
         checkOutput("stall_reach_resp", 64'(bus.resp0_val), 64'd1);
         pend1.push_back('{fn: 1'b0, a: 32'd1, b: 32'd1});
         for (int i = 0; i < 10; i++) begin
            applyStimulus();
            checkOutput("stall_resp0_val", 64'(bus.resp0_val), 64'd1);
            checkOutput("stall_result", bus.resp_msg_result, 64'h00000002_00000006);
            checkOutput("stall_req0_rdy", 64'(bus.req0_rdy), 64'd0);
            checkOutput("stall_req1_rdy", 64'(bus.req1_rdy), 64'd0);
            checkOutput("stall_busy", 64'(bus.busy), 64'd1);
         end
         checkOutput("stall_not_delivered", 64'(done_q.size()), 64'd0);
         resp_force0 = 1;
         bus.resp0_rdy = 1'b1;
         applyStimulus();
         checkOutput("stall_delivered", 64'(done_q.size()), 64'd1);
         checkOutput("stall_resp0_drop", 64'(bus.resp0_val), 64'd0);
         wait_done("stall_next_done", 2, 200);
      end

      // Reset in the middle of WAIT abandons the operation
      begin
         int budget;
         lat_min = 30; lat_max = 30;
         pend0.push_back('{fn: 1'b0, a: 32'd77, b: 32'd5});
         budget = 60;
         while (!bus.divresp_rdy && budget > 0) begin
            applyStimulus();
            budget--;
         end
         checkOutput("midwait_reached", 64'(bus.divresp_rdy), 64'd1);
         repeat (3) applyStimulus();
         reset_n = 1'b0;
         done_q.delete();
         applyStimulus();
         checkOutput("midwait_busy", 64'(bus.busy), 64'd0);
         checkOutput("midwait_resp0_val", 64'(bus.resp0_val), 64'd0);
         checkOutput("midwait_resp1_val", 64'(bus.resp1_val), 64'd0);
         checkOutput("midwait_divreq_val", 64'(bus.divreq_val), 64'd0);
         checkOutput("midwait_result", bus.resp_msg_result, 64'd0);
         checkOutput("midwait_div_reset", 64'(div_reset), 64'd1);
         reset_n = 1'b1;
         lat_min = 0; lat_max = 4;
         pend1.push_back('{fn: 1'b0, a: 32'd9, b: 32'd4});
         wait_done("midwait_fresh_done", 1, 200);
         if (done_q.size() == 1) begin
            checkOutput("midwait_fresh_owner", 64'(done_q[0].owner), 64'd1);
            checkOutput("midwait_fresh_result", done_q[0].dut_res, 64'h00000001_00000002);
         end
      end

      // Randomized traffic checked cycle by cycle against the model
      begin
         int budget;
         done_q.delete();
         auto_push   = 1'b1;
         resp_force0 = -1;
         resp_force1 = -1;
         repeat (3000) applyStimulus();
         auto_push = 1'b0;
         budget = 500;
         while ((m_phase != P_IDLE || pend0.size() > 0 || pend1.size() > 0) && budget > 0) begin
            applyStimulus();
            budget--;
         end
         checkOutput("random_drained", 64'(m_phase == P_IDLE), 64'd1);
         checkOutput("random_progress", 64'(done_q.size() > 20), 64'd1);
         foreach (done_q[i]) begin
            if (done_q[i].dut_res !== done_q[i].mdl_res)
               checkOutput("random_delivery", done_q[i].dut_res, done_q[i].mdl_res);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imuldiv_div_arbiter.md
IMULDIV_DIV_ARBITER -- requirements
Module: imuldiv_div_arbiter

Interface
REQ-001 Parameter PRIO_INIT, default 0: index of the requester that holds round-robin priority after reset.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset is synchronous and active-low; the block resets on a clk edge where reset=0.
REQ-004 req0_val, req1_val  input  1 each  requester N has a valid divide request.
REQ-005 req0_rdy, req1_rdy  output  1 each  the arbiter accepts requester N's request this cycle.
REQ-006 req0_msg_fn, req1_msg_fn  input  1 each  request type: 1=signed, 0=unsigned.
REQ-007 req0_msg_a/b, req1_msg_a/b  input  32 each  dividend and divisor.
REQ-008 resp0_val, resp1_val  output  1 each  a response is available for requester N.
REQ-009 resp0_rdy, resp1_rdy  input  1 each  requester N accepts the response.
REQ-010 resp_msg_result  output  64  shared response payload {remainder[63:32], quotient[31:0]}.
REQ-011 divreq_val / divreq_rdy  output / input  1  request handshake to the shared iterative divider.
REQ-012 divreq_msg_fn, divreq_msg_a, divreq_msg_b  output  1/32/32  registered request payload to the divider.
REQ-013 divresp_val / divresp_rdy  input / output  1  response handshake from the divider.
REQ-014 divresp_msg_result  input  64  divider result.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have four states: IDLE, ISSUE, WAIT, and RESP.
REQ-017 IDLE: a transfer on port N SHALL occur when reqN_val && reqN_rdy.
REQ-018 IDLE arbitration SHALL be:
- only one req_val high: grant that port;
- both high: grant the priority port.
- reqN_rdy is high only for the granted port, and only in IDLE.
REQ-019 On acceptance, the block SHALL:
- latch fn, a, b, and owner id into internal registers;
- set priority to the other port;
- move to ISSUE.
REQ-020 ISSUE: divreq_val=1 with the latched payload; on divreq_rdy=1 the FSM SHALL move to WAIT.
REQ-021 WAIT: divresp_rdy=1; on divresp_val=1 the block SHALL latch divresp_msg_result and move to RESP.
REQ-022 RESP: resp{owner}_val=1 and resp_msg_result holds the latched result; the other resp_val stays 0.
REQ-023 In RESP, on resp{owner}_rdy=1 the FSM SHALL return to IDLE.
REQ-024 divresp_rdy SHALL be 0 outside WAIT, and divreq_val SHALL be 0 outside ISSUE.
REQ-025 The block SHALL NOT accept a new request before the previous response is delivered; at most one operation is in flight.
REQ-026 The arbiter SHALL add no arithmetic: the result is passed bit-exact, and operands and fn are passed unmodified.
REQ-027 Latency SHALL be fixed:
- accept at edge k; divreq_val high in cycle k+1;
- the first resp_val cycle is exactly one cycle after the divresp_val transfer.
REQ-028 All outputs SHALL be driven from state and registers only, except reqN_rdy, which is a function of state, priority and req_val.
REQ-029 reqN_val deasserting while not granted SHALL have no effect; priority SHALL change only on acceptance.
REQ-030 While resp{owner}_rdy=0 in RESP, resp_val and resp_msg_result SHALL hold stable indefinitely.

Reset
REQ-031 When reset=0 at a clk edge, the block SHALL:
- go to IDLE and set priority to PRIO_INIT;
- clear the payload, owner, and result registers to 0.
REQ-032 After reset, outputs SHALL be resp*_val=0, divreq_val=0, divresp_rdy=0, busy=0, resp_msg_result=0.
REQ-033 A reset in any state, including mid-WAIT, SHALL abandon the operation without delivering its response.
REQ-034 The divider SHALL be reset in the same cycle, driven from the inverted reset.

Verification
REQ-035 Single request, port0, fn=0, a=100, b=7 -> resp0_val with result 0x00000002_0000000E; resp1_val never asserted.
REQ-036 Both valid in the first cycle after reset (PRIO_INIT=0): port0 a=20, b=3; port1 a=9, b=4 -> port0 is served first (0x00000002_00000006), then port1 (0x00000001_00000002).
REQ-037 Both requesters holding val continuously for 4 operations -> grants alternate 0,1,0,1; no port is granted twice in a row.
REQ-038 Signed, port1, fn=1, a=-7, b=2 -> resp1 result 0xFFFFFFFF_FFFFFFFD.
REQ-039 resp0_rdy held 0 for 10 cycles in RESP -> resp0_val and the result stay stable, req*_rdy=0, busy=1; delivery occurs on the first cycle resp0_rdy=1.
REQ-040 reset=0 asserted during WAIT -> the next cycle is IDLE, busy=0, no resp_val; a fresh request then completes normally.
